// File: rtl/monster_referee.sv
// Frame-gated referee judging bullet kills, stomps and side contacts against one monster.
// Pulses register 2 Clk after frame_clk is first sampled high; no backpressure, game_over is sticky.
module monster_referee #(
   parameter logic [5:0] COOLDOWN_BASE = 6'd32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  doodle_x,
   input  logic [9:0]  doodle_y,
   input  logic [9:0]  doodle_size,
   input  logic        doodle_falling,
   input  logic [9:0]  bullet_x,
   input  logic [9:0]  bullet_y,
   input  logic        bullet_active,
   input  logic [9:0]  monster_x,
   input  logic [9:0]  monster_y,
   input  logic [9:0]  monster_size_x,
   input  logic [9:0]  monster_size_y,
   input  logic        monster_active,
   input  logic [19:0] random_num,
   output logic        hit,
   output logic        beat_mons,
   output logic        gene,
   output logic        game_over,
   output logic [7:0]  kill_count
);
   typedef enum logic [1:0] {IDLE, LIVE, COOLDOWN, OVER} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_frame_d, r_frame_q, r_armed;
   logic        w_tick;
   logic [6:0]  r_cnt, w_cnt_nxt, w_reload;
   logic        r_hit, r_beat, r_gene, r_over;
   logic        w_hit_nxt, w_beat_nxt, w_gene_nxt, w_over_nxt;
   logic [7:0]  r_kills, w_kills_nxt;
   logic        w_bullet, w_body, w_stomp;
   logic        w_unused;

   function automatic logic [10:0] absdiff(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return (d < 0) ? 11'(-d) : 11'(d);
   endfunction

   // r_armed blocks a tick until frame_clk has been seen low after reset
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_frame_d <= 1'b0;
         r_frame_q <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_frame_d <= frame_clk;
         r_frame_q <= r_frame_d;
         if (!frame_clk)
            r_armed <= 1'b1;
      end
   end
   assign w_tick = r_frame_d & ~r_frame_q & r_armed;

   assign w_bullet = bullet_active
                   && (absdiff(bullet_x, monster_x) <= {1'b0, monster_size_x})
                   && (absdiff(bullet_y, monster_y) <= {1'b0, monster_size_y});
   assign w_body   = (absdiff(doodle_x, monster_x) <= ({1'b0, doodle_size} + {1'b0, monster_size_x}))
                   && (absdiff(doodle_y, monster_y) <= ({1'b0, doodle_size} + {1'b0, monster_size_y}));
   assign w_stomp  = w_body && doodle_falling && (doodle_y < monster_y);
   assign w_reload = {1'b0, COOLDOWN_BASE} + {2'b00, random_num[4:0]};
   assign w_unused = ^random_num[19:5];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hit_nxt   = 1'b0;
      w_beat_nxt  = 1'b0;
      w_gene_nxt  = 1'b0;
      w_over_nxt  = r_over;
      w_kills_nxt = r_kills;
      case (r_state)
         IDLE: begin
            if (monster_active) begin
               w_state_nxt = LIVE;
            end else if (w_tick) begin
               w_cnt_nxt   = {1'b0, COOLDOWN_BASE};
               w_state_nxt = COOLDOWN;
            end
         end
         LIVE: begin
            if (w_tick) begin
               if (!monster_active) begin
                  w_cnt_nxt   = w_reload;
                  w_state_nxt = COOLDOWN;
               end else if (w_bullet || w_stomp) begin
                  // bullet wins over a simultaneous stomp
                  w_hit_nxt   = w_bullet;
                  w_beat_nxt  = ~w_bullet;
                  w_kills_nxt = (r_kills == 8'hFF) ? r_kills : r_kills + 8'd1;
                  w_cnt_nxt   = w_reload;
                  w_state_nxt = COOLDOWN;
               end else if (w_body) begin
                  w_over_nxt  = 1'b1;
                  w_state_nxt = OVER;
               end
            end
         end
         COOLDOWN: begin
            if (w_tick) begin
               if (r_cnt == 7'd0) begin
                  w_gene_nxt  = 1'b1;
                  w_state_nxt = LIVE;
               end else begin
                  w_cnt_nxt = r_cnt - 7'd1;
               end
            end
         end
         OVER:    w_over_nxt  = 1'b1;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_cnt   <= 7'd0;
         r_hit   <= 1'b0;
         r_beat  <= 1'b0;
         r_gene  <= 1'b0;
         r_over  <= 1'b0;
         r_kills <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hit   <= w_hit_nxt;
         r_beat  <= w_beat_nxt;
         r_gene  <= w_gene_nxt;
         r_over  <= w_over_nxt;
         r_kills <= w_kills_nxt;
      end
   end

   assign hit        = r_hit;
   assign beat_mons  = r_beat;
   assign gene       = r_gene;
   assign game_over  = r_over;
   assign kill_count = r_kills;
endmodule

// File: tb/tb_monster_referee.sv
// Bench for monster_referee: directed scenarios plus randomized traffic against a frame-level model.
module tb_monster_referee;
   localparam int BASE = 32;
   localparam int M_IDLE = 0, M_LIVE = 1, M_COOL = 2, M_OVER = 3;

   logic        Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0;
   logic [9:0]  doodle_x = '0, doodle_y = '0, doodle_size = '0;
   logic        doodle_falling = 1'b0;
   logic [9:0]  bullet_x = '0, bullet_y = '0;
   logic        bullet_active = 1'b0;
   logic [9:0]  monster_x = '0, monster_y = '0, monster_size_x = '0, monster_size_y = '0;
   logic        monster_active = 1'b0;
   logic [19:0] random_num = '0;
   logic        hit, beat_mons, gene, game_over;
   logic [7:0]  kill_count;

   int errors = 0, checks = 0;

   monster_referee dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
      .doodle_x(doodle_x), .doodle_y(doodle_y), .doodle_size(doodle_size),
      .doodle_falling(doodle_falling),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
      .monster_x(monster_x), .monster_y(monster_y),
      .monster_size_x(monster_size_x), .monster_size_y(monster_size_y),
      .monster_active(monster_active), .random_num(random_num),
      .hit(hit), .beat_mons(beat_mons), .gene(gene), .game_over(game_over),
      .kill_count(kill_count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: a frame event is seen one Clk after a 0->1 sample of frame_clk
   int m_mode = M_IDLE, m_left = 0, m_prev = -1, e_kill = 0;
   bit m_valid = 0, m_pend = 0, m_tick, m_bov, m_body, m_stomp;
   bit e_hit = 0, e_beat = 0, e_gene = 0, e_over = 0;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_step();
      if (!Reset) begin
         m_valid = 1; m_mode = M_IDLE; m_left = 0; m_prev = -1; m_pend = 0;
         e_hit = 0; e_beat = 0; e_gene = 0; e_over = 0; e_kill = 0;
      end else begin
         m_tick = m_pend;
         m_pend = frame_clk && (m_prev == 0);
         m_prev = int'(frame_clk);
         e_hit = 0; e_beat = 0; e_gene = 0;
         m_bov = bullet_active
                 && iabs(int'(bullet_x) - int'(monster_x)) <= int'(monster_size_x)
                 && iabs(int'(bullet_y) - int'(monster_y)) <= int'(monster_size_y);
         m_body = iabs(int'(doodle_x) - int'(monster_x)) <= int'(doodle_size) + int'(monster_size_x)
                  && iabs(int'(doodle_y) - int'(monster_y)) <= int'(doodle_size) + int'(monster_size_y);
         m_stomp = m_body && doodle_falling && (int'(doodle_y) < int'(monster_y));
         case (m_mode)
            M_IDLE: begin
               if (monster_active) m_mode = M_LIVE;
               else if (m_tick) begin m_left = BASE; m_mode = M_COOL; end
            end
            M_LIVE: begin
               if (m_tick) begin
                  if (!monster_active) begin
                     m_left = BASE + int'(random_num[4:0]); m_mode = M_COOL;
                  end else if (m_bov || m_stomp) begin
                     e_hit = m_bov; e_beat = !m_bov;
                     e_kill = (e_kill >= 255) ? 255 : e_kill + 1;
                     m_left = BASE + int'(random_num[4:0]); m_mode = M_COOL;
                  end else if (m_body) begin
                     e_over = 1; m_mode = M_OVER;
                  end
               end
            end
            M_COOL: begin
               if (m_tick) begin
                  if (m_left == 0) begin e_gene = 1; m_mode = M_LIVE; end
                  else m_left = m_left - 1;
               end
            end
            default: ;
         endcase
      end
   endtask

   initial forever begin
      @(posedge Clk);
      model_step();
   end

   initial forever begin
      @(negedge Clk);
      if (m_valid) begin
         chk("hit", int'(hit), int'(e_hit));
         chk("beat_mons", int'(beat_mons), int'(e_beat));
         chk("gene", int'(gene), int'(e_gene));
         chk("game_over", int'(game_over), int'(e_over));
         chk("kill_count", int'(kill_count), e_kill);
         chk("exclusive", int'((int'(hit) + int'(beat_mons) + int'(gene)) <= 1), 1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b0; frame_clk = 1'b0; step(3); Reset = 1'b1;
   endtask

   task automatic rise();
      frame_clk = 1'b1; step(2);
   endtask

   task automatic fall();
      frame_clk = 1'b0; step(2);
   endtask

   task automatic std_monster();
      monster_x = 10'd330; monster_y = 10'd240; monster_size_x = 10'd20; monster_size_y = 10'd11;
      monster_active = 1'b1;
   endtask

   task automatic park_doodle();
      doodle_x = 10'd100; doodle_y = 10'd100; doodle_size = 10'd12; doodle_falling = 1'b0;
   endtask

   task automatic rand_inputs();
      monster_x = 10'($urandom); monster_y = 10'($urandom);
      monster_size_x = 10'($urandom_range(1, 30)); monster_size_y = 10'($urandom_range(1, 30));
      bullet_active = ($urandom_range(0, 1) == 1);
      bullet_x = monster_x + 10'($urandom_range(0, 70)) - 10'd35;
      bullet_y = monster_y + 10'($urandom_range(0, 70)) - 10'd35;
      doodle_size = 10'($urandom_range(1, 15));
      if ($urandom_range(0, 9) < 2) begin
         doodle_x = monster_x + 10'($urandom_range(0, 80)) - 10'd40;
         doodle_y = monster_y + 10'($urandom_range(0, 60)) - 10'd50;
      end else begin
         doodle_x = 10'($urandom); doodle_y = 10'($urandom);
      end
      doodle_falling = ($urandom_range(0, 3) != 0);
      monster_active = ($urandom_range(0, 9) != 0);
      random_num = 20'($urandom);
   endtask

   initial begin
      int found, gcount, hits, run;
      // reset state
      step(3);
      chk("rst_hit", int'(hit), 0); chk("rst_beat", int'(beat_mons), 0);
      chk("rst_gene", int'(gene), 0); chk("rst_over", int'(game_over), 0);
      chk("rst_kill", int'(kill_count), 0);
      Reset = 1'b1;

      // bullet exactly one pixel outside, then on the inclusive corner
      std_monster(); park_doodle(); random_num = 20'd0;
      bullet_active = 1'b1; bullet_x = 10'd351; bullet_y = 10'd240;
      step(2);
      rise(); chk("miss_bound", int'(hit), 0); fall();
      bullet_x = 10'd350; bullet_y = 10'd251;
      rise(); chk("kill_hit", int'(hit), 1); chk("kill_cnt", int'(kill_count), 1);
      chk("model_kill", e_kill, 1);
      step(1); chk("hit_one_cycle", int'(hit), 0); fall();
      rise(); chk("cooldown_ignores", int'(hit), 0); chk("cooldown_cnt", int'(kill_count), 1); fall();
      rise(); fall();

      // reset mid-cooldown drops the pending respawn
      Reset = 1'b0; step(3);
      chk("midrst_kill", int'(kill_count), 0); chk("midrst_gene", int'(gene), 0);
      Reset = 1'b1; monster_active = 1'b0; gcount = 0;
      for (int i = 0; i < 20; i++) begin
         rise(); gcount += int'(gene); fall(); gcount += int'(gene);
      end
      chk("no_gene_after_rst", gcount, 0);

      // stomp, then respawn on the 38th frame with random_num[4:0]=5
      do_reset(); std_monster(); bullet_active = 1'b0;
      doodle_x = 10'd330; doodle_y = 10'd220; doodle_size = 10'd12; doodle_falling = 1'b1;
      random_num = 20'd5; step(2);
      rise(); chk("stomp_beat", int'(beat_mons), 1); chk("stomp_hit", int'(hit), 0);
      chk("stomp_cnt", int'(kill_count), 1); chk("model_beat", int'(e_beat), 1);
      park_doodle(); fall();
      found = 0;
      for (int i = 1; i <= 45; i++) begin
         rise();
         if (gene && found == 0) found = i;
         fall();
      end
      chk("gene_frame", found, 38);

      // side contact is terminal
      do_reset(); std_monster(); bullet_active = 1'b0;
      doodle_x = 10'd300; doodle_y = 10'd240; doodle_size = 10'd12; doodle_falling = 1'b0;
      step(2);
      rise(); chk("side_over", int'(game_over), 1); chk("side_hit", int'(hit), 0);
      chk("side_beat", int'(beat_mons), 0); fall();
      bullet_active = 1'b1; bullet_x = 10'd350; bullet_y = 10'd251;
      rise(); chk("over_no_hit", int'(hit), 0); chk("over_sticky", int'(game_over), 1);
      chk("over_kill", int'(kill_count), 0); fall();

      // bullet and stomp in the same frame
      do_reset(); std_monster();
      doodle_x = 10'd330; doodle_y = 10'd220; doodle_size = 10'd12; doodle_falling = 1'b1;
      bullet_active = 1'b1; bullet_x = 10'd350; bullet_y = 10'd251; step(2);
      rise(); chk("both_hit", int'(hit), 1); chk("both_beat", int'(beat_mons), 0);
      chk("both_cnt", int'(kill_count), 1); fall();

      // no wraparound across the 0/1023 edge
      do_reset(); std_monster(); monster_x = 10'd5;
      doodle_x = 10'd1020; doodle_y = 10'd240; doodle_size = 10'd12; doodle_falling = 1'b0;
      bullet_active = 1'b1; bullet_x = 10'd1020; bullet_y = 10'd240; step(2);
      rise(); chk("wrap_over", int'(game_over), 0); chk("wrap_hit", int'(hit), 0); fall();

      // frame_clk already high out of reset must not count as a frame
      Reset = 1'b0; frame_clk = 1'b1; std_monster(); park_doodle();
      bullet_active = 1'b1; bullet_x = 10'd350; bullet_y = 10'd251;
      step(3); Reset = 1'b1; step(5);
      chk("no_early_tick", int'(kill_count), 0);
      fall(); rise(); chk("first_tick", int'(kill_count), 1); fall();

      // kill counter saturation: one kill every 34 frames with random_num=0
      do_reset(); std_monster(); park_doodle(); random_num = 20'd0;
      bullet_active = 1'b1; bullet_x = 10'd350; bullet_y = 10'd251; step(2);
      hits = 0;
      for (int t = 0; t < 8680; t++) begin
         frame_clk = 1'b1; step(1); hits += int'(hit);
         frame_clk = 1'b0; step(1); hits += int'(hit);
      end
      chk("sat_hits", hits, 256); chk("sat_kill", int'(kill_count), 255);
      chk("model_sat", e_kill, 255);

      // randomized traffic, checked every cycle against the model
      for (int ep = 0; ep < 6; ep++) begin
         do_reset(); run = 0;
         for (int c = 0; c < 600; c++) begin
            if (run == 0) begin
               frame_clk = ~frame_clk;
               run = $urandom_range(1, 4);
            end
            run--;
            rand_inputs();
            step(1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/monster_referee.md
MONSTER_REFEREE -- requirements
Module: monster_referee

Interface
REQ-001 SHALL have parameter COOLDOWN_BASE, default 6'd32, giving the minimum number of frames between a monster's removal and the next gene pulse.
REQ-002 SHALL have port Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port frame_clk, input, 1 bit: the vertical-sync frame clock, asynchronous to game events.
REQ-005 SHALL have ports doodle_x and doodle_y, input, 10 bits each: the player centre position.
REQ-006 SHALL have port doodle_size, input, 10 bits: the player half-width and half-height.
REQ-007 SHALL have port doodle_falling, input, 1 bit: 1 when the player's vertical velocity is downward.
REQ-008 SHALL have ports bullet_x and bullet_y, input, 10 bits each, and bullet_active, input, 1 bit: the bullet point and its valid flag.
REQ-009 SHALL have ports monster_x and monster_y, input, 10 bits each: the monster centre position.
REQ-010 SHALL have ports monster_size_x and monster_size_y, input, 10 bits each: the monster half-extents.
REQ-011 SHALL have port monster_active, input, 1 bit: the monster's live flag.
REQ-012 SHALL have port random_num, input, 20 bits: a free-running pseudo-random value.
REQ-013 SHALL have port hit, output, 1 bit: a one-Clk pulse meaning the bullet killed the monster.
REQ-014 SHALL have port beat_mons, output, 1 bit: a one-Clk pulse meaning the player stomped the monster.
REQ-015 SHALL have port gene, output, 1 bit: a one-Clk pulse requesting a monster respawn.
REQ-016 SHALL have port game_over, output, 1 bit, sticky: the player touched the monster from the side or from below.
REQ-017 SHALL have port kill_count, output, 8 bits: the number of monsters killed, saturating.

Function
REQ-018 SHALL register frame_clk through a delay flop and raise internal frame_tick for exactly one Clk cycle, the cycle after frame_clk is first sampled high.
REQ-019 SHALL evaluate collisions only in frame_tick cycles and register the resulting pulses one Clk later; latency is 2 Clk from the first high sample of frame_clk.
REQ-020 SHALL compute all position differences in 11-bit signed arithmetic with absolute value, so that no 10-bit wrap occurs near 0 or 1023.
REQ-021 SHALL define bullet overlap as bullet_active AND |bullet_x-monster_x| <= monster_size_x AND |bullet_y-monster_y| <= monster_size_y, with the bounds inclusive.
REQ-022 SHALL define body overlap as |doodle_x-monster_x| <= doodle_size+monster_size_x AND |doodle_y-monster_y| <= doodle_size+monster_size_y, with the bounds inclusive.
REQ-023 SHALL implement FSM states IDLE, LIVE, COOLDOWN and OVER.
REQ-024 SHALL, in IDLE, go to LIVE when monster_active is 1; otherwise, on frame_tick, load the cooldown counter with COOLDOWN_BASE and go to COOLDOWN.
REQ-025 SHALL, in LIVE on frame_tick with monster_active=1, apply this priority: bullet overlap, then stomp (body overlap AND doodle_falling AND doodle_y < monster_y), then side contact (any other body overlap).
REQ-026 SHALL, for a bullet overlap in LIVE, pulse hit, increment kill_count, load the counter with COOLDOWN_BASE + random_num[4:0], and go to COOLDOWN.
REQ-027 SHALL, for a stomp in LIVE, pulse beat_mons and otherwise act exactly as for a bullet overlap.
REQ-028 SHALL, for a side contact in LIVE, set game_over to 1 and go to OVER; hit and beat_mons SHALL NOT pulse.
REQ-029 SHALL, in LIVE with monster_active=0 (monster left the screen), load the counter as in REQ-026 and go to COOLDOWN with no pulse and no kill_count change.
REQ-030 SHALL, in COOLDOWN, decrement the counter once per frame_tick; when a frame_tick finds the counter at 0, it SHALL pulse gene and go to LIVE.
REQ-031 SHALL ignore all collisions while in COOLDOWN, even though the monster block may still report monster_active=1 for a few cycles.
REQ-032 SHALL keep OVER terminal: game_over held at 1, no hit/beat_mons/gene pulses, and kill_count frozen until reset.
REQ-033 SHALL hold kill_count at 255 when an increment would overflow.
REQ-034 SHALL never assert hit, beat_mons or gene in the same cycle as each other.

Reset
REQ-035 SHALL, while Reset=0 at a Clk edge, force the state to IDLE, hit=0, beat_mons=0, gene=0, game_over=0, kill_count=0, the counter to 0, and the frame delay flop to 0.
REQ-036 SHALL, when reset is asserted mid-COOLDOWN or in OVER, abandon all pending counts and emit no gene pulse.
REQ-037 SHALL NOT let the first frame_tick after reset occur until frame_clk has been sampled 0 and then 1.

Verification
REQ-038 Bullet kill: LIVE, monster (330,240) size (20,11), bullet (350,251) active, frame_clk rises -> hit pulses for 1 Clk, 2 Clk after the rise; kill_count=1; state COOLDOWN.
REQ-039 Bullet miss at the bound: same setup, bullet (351,240) -> no hit; state stays LIVE.
REQ-040 Stomp: doodle (330,220) size 12, doodle_falling=1 -> beat_mons pulses; with random_num[4:0]=5 the gene pulse arrives on the 38th subsequent frame_tick.
REQ-041 Side contact: doodle (300,240) size 12, doodle_falling=0 -> game_over=1 and stays 1; a later bullet overlap produces no hit.
REQ-042 Simultaneous events: bullet overlap and stomp in the same frame -> only hit pulses; kill_count increments by 1.
REQ-043 Wrap and reset: monster_x=5, doodle_x=1020 -> no overlap; Reset=0 during COOLDOWN -> all outputs 0 and no gene pulse.
